mc_ctrl: RTL

Multi-cycle control unit sitting directly upstream of the ALU and register file in the MIPS datapath. Decodes the latched instruction's Op/Funct fields and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. Drives every datapath enable and mux select, including the 2-bit ALUOp consumed by the ALU (00 add, 01 sub, other values OR). Uses the ALU Zero flag to resolve beq.

---
 rtl/mc_ctrl_if.sv | 34 +++
 rtl/mc_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between mc_ctrl and the MIPS datapath: decoded IR fields and
// the Zero flag flow in, datapath enables/selects and the debug state flow out.
interface mc_ctrl_if #(
  parameter int ST_W = 4
);
  logic [5:0]      Op;
  logic [5:0]      Funct;
  logic            Zero;
  logic            PCWr;
  logic            IRWr;
  logic            RFWr;
  logic            DMWr;
  logic            ALUSrcB;
  logic            EXTOp;
  logic [1:0]      ALUOp;
  logic [1:0]      NPCOp;
  logic            WDSel;
  logic            GPRSel;
  logic            InstrDone;
  logic            Illegal;
  logic [ST_W-1:0] State;

  modport master (
    input  Op, Funct, Zero,
    output PCWr, IRWr, RFWr, DMWr, ALUSrcB, EXTOp, ALUOp, NPCOp,
           WDSel, GPRSel, InstrDone, Illegal, State
  );

  modport slave (
    output Op, Funct, Zero,
    input  PCWr, IRWr, RFWr, DMWr, ALUSrcB, EXTOp, ALUOp, NPCOp,
           WDSel, GPRSel, InstrDone, Illegal, State
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DCD/EXE/MEM/WB and drives all
// datapath enables and selects. No handshake; the datapath follows the state.
module mc_ctrl #(
  parameter int ST_W = 4
) (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_MA    = 4'd2,
    S_MR    = 4'd3,
    S_MW    = 4'd4,
    S_MWB   = 4'd5,
    S_EXE   = 4'd6,
    S_AWB   = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9
  } state_t;

  state_t state, next_state;

  logic is_rtype, r_addu, r_subu, r_or, r_legal;
  logic is_lw, is_sw, is_addiu, is_ori, is_beq, is_j;
  logic       alu_srcb, alu_ext;
  logic [1:0] alu_op;

  always_comb begin
    is_rtype = (bus.Op == 6'b000000);
    r_addu   = is_rtype && (bus.Funct == 6'b100001);
    r_subu   = is_rtype && (bus.Funct == 6'b100011);
    r_or     = is_rtype && (bus.Funct == 6'b100101);
    r_legal  = r_addu || r_subu || r_or;
    is_lw    = (bus.Op == 6'b100011);
    is_sw    = (bus.Op == 6'b101011);
    is_addiu = (bus.Op == 6'b001001);
    is_ori   = (bus.Op == 6'b001101);
    is_beq   = (bus.Op == 6'b000100);
    is_j     = (bus.Op == 6'b000010);
  end

  // ALU setup shared by EXE and AWB so the result stays valid through writeback.
  always_comb begin
    alu_srcb = !is_rtype;
    alu_ext  = is_addiu;
    if (is_rtype)
      alu_op = r_subu ? 2'b01 : (r_or ? 2'b10 : 2'b00);
    else
      alu_op = is_ori ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state    = S_FETCH;
    bus.PCWr      = 1'b0;
    bus.IRWr      = 1'b0;
    bus.RFWr      = 1'b0;
    bus.DMWr      = 1'b0;
    bus.ALUSrcB   = 1'b0;
    bus.EXTOp     = 1'b0;
    bus.ALUOp     = 2'b00;
    bus.NPCOp     = 2'b00;
    bus.WDSel     = 1'b0;
    bus.GPRSel    = 1'b0;
    bus.InstrDone = 1'b0;
    bus.Illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        bus.IRWr   = 1'b1;
        bus.PCWr   = 1'b1;
        next_state = S_DCD;
      end
      S_DCD: begin
        if (r_legal || is_addiu || is_ori) next_state = S_EXE;
        else if (is_lw || is_sw)           next_state = S_MA;
        else if (is_beq)                   next_state = S_BR;
        else if (is_j)                     next_state = S_JMP;
        else                               bus.Illegal = 1'b1;
      end
      S_MA: begin
        bus.ALUSrcB = 1'b1;
        bus.EXTOp   = 1'b1;
        next_state  = is_lw ? S_MR : S_MW;
      end
      S_MR:  next_state = S_MWB;
      S_MWB: begin
        bus.RFWr      = 1'b1;
        bus.WDSel     = 1'b1;
        bus.GPRSel    = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_MW: begin
        bus.DMWr      = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_EXE: begin
        bus.ALUSrcB = alu_srcb;
        bus.EXTOp   = alu_ext;
        bus.ALUOp   = alu_op;
        next_state  = S_AWB;
      end
      S_AWB: begin
        bus.ALUSrcB   = alu_srcb;
        bus.EXTOp     = alu_ext;
        bus.ALUOp     = alu_op;
        bus.RFWr      = 1'b1;
        bus.GPRSel    = !is_rtype;
        bus.InstrDone = 1'b1;
      end
      S_BR: begin
        bus.ALUOp     = 2'b01;
        bus.NPCOp     = 2'b01;
        bus.PCWr      = bus.Zero;
        bus.InstrDone = 1'b1;
      end
      S_JMP: begin
        bus.NPCOp     = 2'b10;
        bus.PCWr      = 1'b1;
        bus.InstrDone = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
    // State already reads FETCH under reset; this silences FETCH's enables too.
    if (rst) begin
      bus.PCWr      = 1'b0;
      bus.IRWr      = 1'b0;
      bus.RFWr      = 1'b0;
      bus.DMWr      = 1'b0;
      bus.ALUSrcB   = 1'b0;
      bus.EXTOp     = 1'b0;
      bus.ALUOp     = 2'b00;
      bus.NPCOp     = 2'b00;
      bus.WDSel     = 1'b0;
      bus.GPRSel    = 1'b0;
      bus.InstrDone = 1'b0;
      bus.Illegal   = 1'b0;
    end
  end

  assign bus.State = ST_W'(state);

endmodule
